// File: rtl/harmonic_synth_pkg.sv
// Shared types, constants and the quarter-wave sine generator for harmonic_synth.
package harmonic_synth_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_t;

    localparam int UNITY_GAIN = 8;
    localparam int GAIN_SHIFT = $clog2(UNITY_GAIN);
    localparam int LUT_IDX_W  = 12;
    localparam int QTR_ADDR_W = 10;
    localparam int SINE_W     = 16;
    localparam logic signed [SINE_W-1:0] SINE_MAX = 16'sd32767;

    // pi/2 in Q60 fixed point
    localparam logic signed [127:0] PI_HALF_Q60 = 128'sd1811004864519280774;

    // round(32767 * sin(pi/2 * a/1024)) by a Q60 Taylor series, evaluated at elaboration
    function automatic logic signed [SINE_W-1:0] quarter_sine(input int unsigned a);
        logic signed [127:0] x, x2, term, sum, d;
        x    = (PI_HALF_Q60 * $signed(128'(a))) >>> QTR_ADDR_W;
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            d    = 128'((2 * n) * (2 * n + 1));
            term = -(((term * x2) >>> 60) / d);
            sum  = sum + term;
        end
        return SINE_W'((sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60);
    endfunction

endpackage

// File: rtl/harmonic_synth_if.sv
// Request/response bundle between the note player and harmonic_synth.
interface harmonic_synth_if #(
    parameter int NUM_HARM = 4,
    parameter int STEP_W   = 20,
    parameter int SAMPLE_W = 18,
    parameter int GAIN_W   = 4
);
    logic                         play_enable;
    logic                         generate_next;
    logic [STEP_W-1:0]            step_size;
    logic                         harm_mode;
    logic [NUM_HARM*GAIN_W-1:0]   gains;
    logic signed [SAMPLE_W-1:0]   harmonic_out;
    logic                         sample_ready;
    logic                         overrun;

    modport master (
        output play_enable, generate_next, step_size, harm_mode, gains,
        input  harmonic_out, sample_ready, overrun
    );

    modport slave (
        input  play_enable, generate_next, step_size, harm_mode, gains,
        output harmonic_out, sample_ready, overrun
    );
endinterface

// File: rtl/harmonic_synth_sine_lut.sv
// 12-bit phase index to signed 16-bit sine, quarter-wave table, one cycle latency.
module harmonic_sine_lut
    import harmonic_synth_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LUT_IDX_W-1:0]        idx,
    output logic signed [SINE_W-1:0]    q
);
    logic signed [SINE_W-1:0] rom [2**QTR_ADDR_W];

    for (genvar gi = 0; gi < 2**QTR_ADDR_W; gi++) begin : g_rom
        localparam logic signed [SINE_W-1:0] V = quarter_sine(gi);
        assign rom[gi] = V;
    end

    quad_t                    quad;
    logic [QTR_ADDR_W-1:0]    a, addr;
    logic                     peak;
    logic signed [SINE_W-1:0] mag;

    // Odd quadrants read the table at 1024-a; a==0 there is the crest, which the table lacks.
    always_comb begin
        quad = quad_t'(idx[LUT_IDX_W-1 -: 2]);
        a    = idx[QTR_ADDR_W-1:0];
        addr = a;
        peak = 1'b0;
        if (quad == QUAD_1 || quad == QUAD_3) begin
            addr = -a;
            peak = (a == '0);
        end
        mag = peak ? SINE_MAX : rom[addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= (quad == QUAD_2 || quad == QUAD_3) ? -mag : mag;
    end
endmodule

// File: rtl/harmonic_synth.sv
// Additive voice: NUM_HARM phase accumulators sharing one sine LUT, gain MAC, saturated sum.
module harmonic_synth
    import harmonic_synth_pkg::*;
#(
    parameter int NUM_HARM = 4,
    parameter int STEP_W   = 20,
    parameter int ACC_W    = 22,
    parameter int SAMPLE_W = 18,
    parameter int GAIN_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    harmonic_synth_if.slave bus
);
    localparam int K_W    = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
    localparam int MAC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_HARM);
    localparam int PROD_W = SINE_W + GAIN_W + 1;
    localparam logic [K_W-1:0]          K_LAST  = K_W'(NUM_HARM - 1);
    localparam logic signed [MAC_W-1:0] SAT_MAX = MAC_W'((2**(SAMPLE_W-1)) - 1);
    localparam logic signed [MAC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                              state, state_nxt;
    logic [K_W-1:0]                      k, k_d;
    logic                                mac_vld;
    logic [NUM_HARM-1:0][ACC_W-1:0]      phase;
    logic [STEP_W-1:0]                   step_lat;
    logic                                mode_lat;
    logic [NUM_HARM-1:0][GAIN_W-1:0]     gain_lat;
    logic [ACC_W-1:0]                    step_k;
    logic signed [SINE_W-1:0]            lut_q;
    logic signed [PROD_W-1:0]            prod;
    logic signed [MAC_W-1:0]             mac, mac_sum;
    logic                                accept;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [MAC_W-1:0] m);
        logic signed [MAC_W-1:0] s;
        s = m >>> GAIN_SHIFT;
        if (s > SAT_MAX)      return SAMPLE_W'(SAT_MAX);
        else if (s < SAT_MIN) return SAMPLE_W'(SAT_MIN);
        else                  return SAMPLE_W'(s);
    endfunction

    harmonic_sine_lut u_lut (
        .clk   (clk),
        .reset (reset),
        .idx   (phase[k][ACC_W-1 -: LUT_IDX_W]),
        .q     (lut_q)
    );

    assign accept = (state == IDLE) && bus.generate_next && bus.play_enable;

    always_comb begin
        if (mode_lat) step_k = ACC_W'(step_lat >> k);
        else          step_k = ACC_W'(ACC_W'(step_lat) * ACC_W'({1'b0, k} + 1'b1));
    end

    // LUT output lags the index by a cycle, so the MAC works on partial k_d
    assign prod    = lut_q * $signed({1'b0, gain_lat[k_d]});
    assign mac_sum = mac + MAC_W'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (k == K_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k                <= '0;
            k_d              <= '0;
            mac_vld          <= 1'b0;
            phase            <= '0;
            step_lat         <= '0;
            mode_lat         <= 1'b0;
            gain_lat         <= '0;
            mac              <= '0;
            bus.harmonic_out <= '0;
            bus.sample_ready <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            k_d              <= k;
            mac_vld          <= (state == ISSUE);
            bus.overrun      <= bus.generate_next && (state != IDLE);
            bus.sample_ready <= (state == DRAIN);
            if (accept) begin
                step_lat <= bus.step_size;
                mode_lat <= bus.harm_mode;
                gain_lat <= bus.gains;
                mac      <= '0;
                k        <= '0;
            end
            if (state == ISSUE) begin
                phase[k] <= phase[k] + step_k;
                k        <= (k == K_LAST) ? '0 : K_W'(k + 1'b1);
            end
            if (mac_vld) mac <= mac_sum;
            // Output is loaded with the final partial so it is valid while sample_ready is high
            if (state == DRAIN) bus.harmonic_out <= saturate(mac_sum);
        end
    end
endmodule
